// File: rtl/sha256_msg_schedule_pkg.sv
// Shared SHA-256 types, constants and small-sigma helpers for the message schedule.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int SHA256_ROUNDS = 64;
    localparam int SCHED_WINDOW  = 16;

    typedef enum logic {
        LOAD   = 1'b0,
        EXPAND = 1'b1
    } sched_state_e;

    // s0(x) = rotr7 ^ rotr18 ^ shr3, written as fixed bit re-wiring
    function automatic word_t ssig0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // s1(x) = rotr17 ^ rotr19 ^ shr10
    function automatic word_t ssig1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Input word stream and output schedule-word stream of the message scheduler.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both streams.
interface sha256_msg_schedule_if;
    import sha256_pkg::*;

    logic       in_valid;
    logic       in_ready;
    word_t      in_word;
    logic       out_valid;
    logic       out_ready;
    word_t      out_word;
    logic [5:0] out_idx;
    logic       out_last;

    // The scheduler itself
    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word, out_idx, out_last
    );

    // Padder / round datapath side
    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word, out_idx, out_last
    );

endinterface

// File: rtl/sha256_msg_schedule_ssig.sv
// Small-sigma pair s0/s1 for the schedule recurrence.
// Latency: combinational.
// Backpressure: none.
module sha256_msg_schedule_ssig
    import sha256_pkg::*;
(
    input  word_t s0_in_i,
    input  word_t s1_in_i,
    output word_t s0_o,
    output word_t s1_o
);

    assign s0_o = ssig0(s0_in_i);
    assign s1_o = ssig1(s1_in_i);

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: takes M_0..M_15, emits W_0..W_(NUM_WORDS-1), one word per cycle.
// Latency: 1 cycle input-to-output in LOAD; expanded words follow back-to-back.
// Backpressure: output register holds while out_valid & !out_ready; in_ready drops and expansion stalls.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int NUM_WORDS = SHA256_ROUNDS
) (
    input  logic                  clk,
    input  logic                  rst,
    sha256_msg_schedule_if.slave  sched
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

    sched_state_e state_q;
    logic [5:0]   cnt_q;
    word_t        win_q [SCHED_WINDOW];
    word_t        out_word_q;
    logic [5:0]   out_idx_q;
    logic         out_valid_q;
    logic         out_last_q;

    word_t        s0_w;
    word_t        s1_w;
    word_t        exp_word_d;
    word_t        push_word_d;
    logic         slot_free;
    logic         in_rdy;
    logic         in_fire;
    logic         exp_fire;
    logic         push;
    logic         last_push;

    sha256_msg_schedule_ssig u_ssig (
        .s0_in_i (win_q[1]),
        .s1_in_i (win_q[14]),
        .s0_o    (s0_w),
        .s1_o    (s1_w)
    );

    // The output register can take a new word when empty or being drained this cycle
    assign slot_free   = !out_valid_q || sched.out_ready;
    assign in_rdy      = (state_q == LOAD) && slot_free;
    assign in_fire     = sched.in_valid && in_rdy;
    assign exp_fire    = (state_q == EXPAND) && slot_free;
    assign push        = in_fire || exp_fire;
    assign last_push   = exp_fire && (cnt_q == LAST_IDX);

    // W_t = s1(W_(t-2)) + W_(t-7) + s0(W_(t-15)) + W_(t-16), mod 2^32
    assign exp_word_d  = s1_w + win_q[9] + s0_w + win_q[0];
    assign push_word_d = (state_q == EXPAND) ? exp_word_d : sched.in_word;

    assign sched.in_ready  = in_rdy;
    assign sched.out_valid = out_valid_q;
    assign sched.out_word  = out_word_q;
    assign sched.out_idx   = out_idx_q;
    assign sched.out_last  = out_last_q;

    // FSM, word counter and output register advance together on every pushed word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else if (push) begin
            out_word_q  <= push_word_d;
            out_idx_q   <= cnt_q;
            out_valid_q <= 1'b1;
            out_last_q  <= last_push;
            if (last_push) begin
                cnt_q   <= '0;
                state_q <= LOAD;
            end else begin
                cnt_q   <= cnt_q + 6'd1;
                if (in_fire && (cnt_q == 6'd15)) begin
                    state_q <= EXPAND;
                end
            end
        end else if (slot_free) begin
            out_valid_q <= 1'b0;
        end
    end

    // Sliding window of the last 16 words; contents are meaningless until refilled after reset
    always_ff @(posedge clk) begin
        if (push) begin
            for (int k = 0; k < SCHED_WINDOW - 1; k++) begin
                win_q[k] <= win_q[k + 1];
            end
            win_q[SCHED_WINDOW - 1] <= push_word_d;
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;
    import sha256_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // shared stimulus, one DUT observed at a time
    logic  in_valid;
    logic  out_ready;
    word_t in_word;
    bit    sel;

    sha256_msg_schedule_if ifc64 ();
    sha256_msg_schedule_if ifc20 ();

    sha256_msg_schedule #(.NUM_WORDS(64)) dut64 (.clk(clk), .rst(rst), .sched(ifc64));
    sha256_msg_schedule #(.NUM_WORDS(20)) dut20 (.clk(clk), .rst(rst), .sched(ifc20));

    always_comb begin
        ifc64.in_valid  = in_valid;
        ifc64.in_word   = in_word;
        ifc64.out_ready = out_ready;
        ifc20.in_valid  = in_valid;
        ifc20.in_word   = in_word;
        ifc20.out_ready = out_ready;
    end

    logic       o_valid;
    logic       o_in_ready;
    word_t      o_word;
    logic [5:0] o_idx;
    logic       o_last;

    always_comb begin
        if (sel) begin
            o_valid = ifc20.out_valid; o_in_ready = ifc20.in_ready; o_word = ifc20.out_word;
            o_idx = ifc20.out_idx; o_last = ifc20.out_last;
        end else begin
            o_valid = ifc64.out_valid; o_in_ready = ifc64.in_ready; o_word = ifc64.out_word;
            o_idx = ifc64.out_idx; o_last = ifc64.out_last;
        end
    end

    // stimulus, software model and captured results
    word_t      in_words [64];
    word_t      model_w  [128];
    word_t      got_word [128];
    logic [5:0] got_idx  [128];
    logic       got_last [128];
    int         in_cyc   [64];
    int         out_cyc  [128];
    int         n_in, n_out, stab_err, busy_err, expand_err;
    bit         timed_out;
    word_t      stop_word;

    function automatic word_t m_rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t m_s0(input word_t x);
        return m_rotr(x, 7) ^ m_rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t m_s1(input word_t x);
        return m_rotr(x, 17) ^ m_rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model(input int nwords, input int nblocks);
        word_t w [64];
        for (int b = 0; b < nblocks; b++) begin
            for (int t = 0; t < nwords; t++) begin
                if (t < 16) w[t] = in_words[16 * b + t];
                else        w[t] = m_s1(w[t - 2]) + w[t - 7] + m_s0(w[t - 15]) + w[t - 16];
                model_w[b * nwords + t] = w[t];
            end
        end
    endtask

    task automatic load_blocks();
        for (int i = 0; i < 16; i++) begin
            in_words[i]      = 32'h0;
            in_words[16 + i] = 32'h9E37_79B9 * word_t'(i + 1);
        end
        in_words[0]  = 32'h6162_6380;
        in_words[15] = 32'h0000_0018;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drives words and out_ready, captures every handshake; stops after nwords*nblocks outputs
    // or, if stop_idx >= 0, at the first cycle presenting out_idx == stop_idx.
    task automatic drive(input bit sel_i, input int nwords, input int nblocks, input int n_words_in,
                         input int rdy_pct, input bit hold_v, input int stop_idx);
        bit         done, stopped, prev_stall, ofire, ifire;
        word_t      prev_word;
        logic [5:0] prev_idx;
        logic       prev_last;
        int         done_after;
        sel = sel_i;
        n_in = 0; n_out = 0; stab_err = 0; busy_err = 0; expand_err = 0; timed_out = 1'b1;
        done = 1'b0; stopped = 1'b0; prev_stall = 1'b0;
        prev_word = '0; prev_idx = '0; prev_last = 1'b0;
        for (int c = 0; c < 3000 && !done && !stopped; c++) begin
            @(negedge clk);
            if (prev_stall && (o_valid !== 1'b1 || o_word !== prev_word || o_idx !== prev_idx || o_last !== prev_last))
                stab_err++;
            if (stop_idx >= 0 && o_valid === 1'b1 && o_idx == 6'(stop_idx)) begin
                stop_word = o_word;
                stopped = 1'b1;
            end else begin
                out_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
                if (n_in < n_words_in) begin
                    in_valid = 1'b1; in_word = in_words[n_in];
                end else begin
                    in_valid = hold_v; in_word = 32'hDEAD_BEEF;
                end
                #1;
                ofire = o_valid & out_ready;
                ifire = in_valid & o_in_ready;
                if (o_valid && !out_ready && o_in_ready) busy_err++;
                done_after = (n_out + int'(ofire)) / nwords;
                if (o_in_ready && n_in >= 16 * (done_after + 1)) expand_err++;
                if (ifire) begin
                    in_cyc[n_in] = cyc; n_in++;
                end
                if (ofire) begin
                    got_word[n_out] = o_word; got_idx[n_out] = o_idx; got_last[n_out] = o_last;
                    out_cyc[n_out] = cyc; n_out++;
                end
                prev_stall = o_valid & !out_ready;
                prev_word = o_word; prev_idx = o_idx; prev_last = o_last;
                if (n_out >= nwords * nblocks) done = 1'b1;
            end
        end
        if (stopped) begin
            timed_out = 1'b0;
        end else if (done) begin
            @(posedge clk);
            #1 in_valid = 1'b0; out_ready = 1'b1;
            timed_out = 1'b0;
        end
    endtask

    task automatic test_reset();
        sel = 1'b0; rst = 1'b1; in_valid = 1'b1; in_word = 32'h1234_5678; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", o_valid); end
        total++; if (o_word !== 32'h0) begin bad++; $display("FAIL reset_out_word got=%h exp=0", o_word); end
        total++; if (o_idx !== 6'd0) begin bad++; $display("FAIL reset_out_idx got=%0d exp=0", o_idx); end
        total++; if (o_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", o_last); end
        total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", o_in_ready); end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_abc();
        do_reset(); load_blocks(); build_model(64, 1);
        drive(1'b0, 64, 1, 16, 100, 1'b0, -1);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL abc_timeout got=%b exp=0", timed_out); end
        total++; if (n_out !== 64) begin bad++; $display("FAIL abc_out_count got=%0d exp=64", n_out); end
        total++; if (n_in !== 16) begin bad++; $display("FAIL abc_in_count got=%0d exp=16", n_in); end
        for (int i = 0; i < 64; i++) begin
            total++;
            if (got_word[i] !== model_w[i] || got_idx[i] !== 6'(i) || got_last[i] !== (i == 63)) begin
                bad++;
                $display("FAIL abc_seq t=%0d got w=%h idx=%0d last=%b exp w=%h idx=%0d last=%b",
                         i, got_word[i], got_idx[i], got_last[i], model_w[i], i, (i == 63));
            end
        end
        total++; if (got_word[16] !== 32'h6162_6380) begin bad++; $display("FAIL abc_w16 got=%h exp=61626380", got_word[16]); end
        total++; if (got_word[17] !== 32'h000F_0000) begin bad++; $display("FAIL abc_w17 got=%h exp=000f0000", got_word[17]); end
        total++; if (got_word[63] !== 32'h12B1_EDEB) begin bad++; $display("FAIL abc_w63 got=%h exp=12b1edeb", got_word[63]); end
        total++; if (got_last[63] !== 1'b1 || got_idx[63] !== 6'd63) begin
            bad++; $display("FAIL abc_last got last=%b idx=%0d exp last=1 idx=63", got_last[63], got_idx[63]);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (out_cyc[i] !== in_cyc[i] + 1) begin
                bad++; $display("FAIL abc_latency t=%0d got=%0d exp=%0d", i, out_cyc[i], in_cyc[i] + 1);
            end
        end
        total++; if (out_cyc[63] - out_cyc[0] !== 63) begin
            bad++; $display("FAIL abc_throughput got=%0d exp=63", out_cyc[63] - out_cyc[0]);
        end
    endtask

    task automatic test_backpressure();
        do_reset(); load_blocks(); build_model(64, 1);
        drive(1'b0, 64, 1, 16, 50, 1'b0, -1);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL bp_timeout got=%b exp=0", timed_out); end
        total++; if (n_out !== 64) begin bad++; $display("FAIL bp_out_count got=%0d exp=64", n_out); end
        for (int i = 0; i < 64; i++) begin
            total++;
            if (got_word[i] !== model_w[i] || got_idx[i] !== 6'(i) || got_last[i] !== (i == 63)) begin
                bad++;
                $display("FAIL bp_seq t=%0d got w=%h idx=%0d last=%b exp w=%h idx=%0d", i,
                         got_word[i], got_idx[i], got_last[i], model_w[i], i);
            end
        end
        total++; if (stab_err !== 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stab_err); end
        total++; if (busy_err !== 0) begin bad++; $display("FAIL bp_in_ready_busy got=%0d exp=0", busy_err); end
    endtask

    task automatic test_back_to_back();
        do_reset(); load_blocks(); build_model(64, 2);
        drive(1'b0, 64, 2, 32, 100, 1'b1, -1);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL b2b_timeout got=%b exp=0", timed_out); end
        for (int i = 0; i < 128; i++) begin
            total++;
            if (got_word[i] !== model_w[i] || got_idx[i] !== 6'(i % 64) || got_last[i] !== ((i % 64) == 63)) begin
                bad++;
                $display("FAIL b2b_seq n=%0d got w=%h idx=%0d last=%b exp w=%h idx=%0d", i,
                         got_word[i], got_idx[i], got_last[i], model_w[i], i % 64);
            end
        end
        total++; if (in_cyc[16] !== out_cyc[63]) begin
            bad++; $display("FAIL b2b_m0_with_w63 got=%0d exp=%0d", in_cyc[16], out_cyc[63]);
        end
        total++; if (out_cyc[127] - out_cyc[0] !== 127) begin
            bad++; $display("FAIL b2b_no_bubble got=%0d exp=127", out_cyc[127] - out_cyc[0]);
        end
        total++; if (n_in !== 33) begin bad++; $display("FAIL b2b_in_count got=%0d exp=33", n_in); end
    endtask

    task automatic test_rst_mid();
        do_reset(); load_blocks(); build_model(64, 1);
        drive(1'b0, 64, 1, 16, 100, 1'b0, 20);
        total++; if (timed_out !== 1'b0 || stop_word !== model_w[20]) begin
            bad++; $display("FAIL rstmid_w20 got=%h exp=%h timeout=%b", stop_word, model_w[20], timed_out);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b exp=0", o_valid); end
        total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b exp=1", o_in_ready); end
        total++; if (o_word !== 32'h0 || o_idx !== 6'd0 || o_last !== 1'b0) begin
            bad++; $display("FAIL rstmid_fields got w=%h idx=%0d last=%b exp 0/0/0", o_word, o_idx, o_last);
        end
        drive(1'b0, 64, 1, 16, 100, 1'b0, -1);
        total++; if (timed_out !== 1'b0 || n_out !== 64) begin
            bad++; $display("FAIL rstmid_count got=%0d exp=64 timeout=%b", n_out, timed_out);
        end
        for (int i = 0; i < 64; i++) begin
            total++;
            if (got_word[i] !== model_w[i] || got_idx[i] !== 6'(i)) begin
                bad++; $display("FAIL rstmid_seq t=%0d got w=%h idx=%0d exp w=%h", i, got_word[i], got_idx[i], model_w[i]);
            end
        end
    endtask

    task automatic test_expand_hold();
        do_reset(); load_blocks(); build_model(64, 1);
        drive(1'b0, 64, 1, 16, 60, 1'b1, -1);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL hold_timeout got=%b exp=0", timed_out); end
        total++; if (expand_err !== 0) begin bad++; $display("FAIL hold_in_ready_expand got=%0d exp=0", expand_err); end
        total++; if (n_in !== 17) begin bad++; $display("FAIL hold_in_count got=%0d exp=17", n_in); end
        total++; if (in_cyc[16] !== out_cyc[63]) begin
            bad++; $display("FAIL hold_next_m0 got=%0d exp=%0d", in_cyc[16], out_cyc[63]);
        end
        for (int i = 16; i < 64; i++) begin
            total++;
            if (got_word[i] !== model_w[i]) begin
                bad++; $display("FAIL hold_seq t=%0d got=%h exp=%h", i, got_word[i], model_w[i]);
            end
        end
    endtask

    task automatic test_num_words20();
        do_reset(); load_blocks(); build_model(20, 2);
        drive(1'b1, 20, 2, 32, 100, 1'b0, -1);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL nw20_timeout got=%b exp=0", timed_out); end
        for (int i = 0; i < 40; i++) begin
            total++;
            if (got_word[i] !== model_w[i] || got_idx[i] !== 6'(i % 20) || got_last[i] !== ((i % 20) == 19)) begin
                bad++;
                $display("FAIL nw20_seq n=%0d got w=%h idx=%0d last=%b exp w=%h idx=%0d", i,
                         got_word[i], got_idx[i], got_last[i], model_w[i], i % 20);
            end
        end
        total++; if (got_word[16] !== 32'h6162_6380 || got_word[17] !== 32'h000F_0000) begin
            bad++; $display("FAIL nw20_w16_w17 got=%h %h exp=61626380 000f0000", got_word[16], got_word[17]);
        end
        total++; if (in_cyc[16] !== out_cyc[19]) begin
            bad++; $display("FAIL nw20_reload got=%0d exp=%0d", in_cyc[16], out_cyc[19]);
        end
        sel = 1'b0;
    endtask

    initial begin
        in_valid = 1'b0; in_word = '0; out_ready = 1'b0; sel = 1'b0;
        test_reset();
        test_abc();
        test_backpressure();
        test_back_to_back();
        test_rst_mid();
        test_expand_hold();
        test_num_words20();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- Sequential SHA-256 message-schedule generator: the producer side of the W_t word stream consumed by the compression rounds (Sigma0/Sigma1 rotate units).
- Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready input stream.
- Emits W_0..W_63 in order over a valid/ready output stream, one word per cycle at full throughput.
- Sits between the block padder and the round datapath.

Parameters:
- NUM_WORDS, 64, total schedule words emitted per block (legal range 17..64; 64 for SHA-256).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_word is valid
- in_ready  output  1  block accepts in_word this cycle
- in_word  input  32  message word M_i, i = 0..15 in order
- out_valid  output  1  out_word holds W_t
- out_ready  input  1  consumer accepts out_word this cycle
- out_word  output  32  schedule word W_t
- out_idx  output  6  t of the word currently presented
- out_last  output  1  high with W_(NUM_WORDS-1)

Behaviour:
- Reset: one clock and a synchronous, active-high reset. rst sampled on the clk edge.
  - Reset values: state=LOAD, cnt=0, out_valid=0, out_word=0, out_idx=0, out_last=0.
  - Window registers are don't-care after reset.
- Storage:
  - 16-entry window w[0..15]; w[0] = W_(t-16) (oldest), w[15] = W_(t-1) (newest).
  - One output register (out_word/out_idx/out_last/out_valid).
  - 6-bit counter cnt = index of the next word to produce.
- Output register update: "slot free" = !out_valid | out_ready. The output register only loads when the slot is free. Otherwise it holds all fields stable (no change while out_valid & !out_ready).
- State LOAD (cnt 0..15):
  - in_ready = slot free.
  - On in_valid & in_ready:
    - out_word <= in_word, out_idx <= cnt, out_valid <= 1.
    - Window shifts left (w[k] <= w[k+1]), w[15] <= in_word.
    - cnt++.
  - When the accepted word has cnt==15, go to EXPAND.
  - Latency in -> out is 1 cycle.
- State EXPAND (cnt 16..NUM_WORDS-1):
  - in_ready = 0.
  - Next word is computed combinationally from the window: W = s1(w[14]) + w[9] + s0(w[1]) + w[0], addition mod 2^32.
    - s0(x) = rotr7(x) ^ rotr18(x) ^ shr3(x)
    - s1(x) = rotr17(x) ^ rotr19(x) ^ shr10(x)
  - When the slot is free:
    - out_word <= W, out_idx <= cnt, out_valid <= 1.
    - Window shifts with w[15] <= W.
    - cnt++.
  - When cnt==NUM_WORDS-1 is loaded: set out_last <= 1, cnt <= 0, state <= LOAD.
- out_last is registered alongside out_word. It is cleared when a non-last word is loaded.
- A consumed output with no new load (slot free, nothing to load) sets out_valid <= 0.
- Back-to-back blocks:
  - M_0 of the next block may be accepted in the cycle the last word of the prior block is consumed (out_ready high).
  - No bubble is required between blocks.
- Throughput: 1 word/cycle with out_ready held high. A full block takes 16 input cycles plus NUM_WORDS-16 expand cycles.
- Back-pressure: out_ready low stalls both LOAD (in_ready=0) and EXPAND. No word is ever dropped or duplicated.
- rst mid-block: the block is abandoned, the outputs clear to reset values, and the next accepted word is M_0 of a new block.
- in_valid during EXPAND is ignored (in_ready=0). The upstream must hold it.

Decomposition:
- Shared package sha256_pkg:
  - word_t (logic [31:0])
  - SHA256_ROUNDS = 64, SCHED_WINDOW = 16
  - functions ssig0/ssig1 (small sigma) built from fixed rotate/shift
  - state enum {LOAD, EXPAND}
- One natural sub-module: sha256_ssig, combinational, computing s0 and s1 of its inputs. The existing fixed-rotate modules can be reused inside it.

Test Plan:
- "abc" padded block, out_ready=1: M_0=0x61626380, M_1..M_14=0, M_15=0x00000018.
  - W_0..W_15 echo the inputs one cycle after acceptance.
  - W_16=0x61626380, W_17=0x000F0000.
  - W_63=0x12B1EDEB with out_last=1, out_idx=63.
  - Exactly 64 handshakes.
- Same block with out_ready toggling pseudo-randomly (about 50%):
  - Identical 64-word sequence.
  - out_word/out_idx stable whenever out_valid & !out_ready.
  - in_ready low whenever the slot is busy.
- Two blocks back-to-back, in_valid always high: the second block's M_0 is accepted in the same cycle W_63 is consumed. Both sequences match the software model.
- Assert rst on the cycle after W_20 is emitted:
  - Next cycle out_valid=0, in_ready=1.
  - A fresh "abc" block produces a correct W_0..W_63.
- in_valid held high during EXPAND: in_ready stays 0 for all 48 expand words, and no input is consumed.
- NUM_WORDS=20: out_last on W_19, then return to LOAD. W_16..W_19 match the model.
